// File: rtl/xmtr_if.sv
// Host-side bundle for the serial frame transmitter.
//   data_in  : byte to send, sampled while writing is high
//   writing  : write strobe, one byte per cycle high
//   empty    : holding register free (registered)
//   overrun  : sticky, a write hit a full holding register (registered)
//   data_out : serial line, idles low (registered)
// master = host / line side, slave = the transmitter.
interface xmtr_if;
  logic [7:0] data_in;
  logic       writing;
  logic       empty;
  logic       overrun;
  logic       data_out;

  modport master (output data_in, writing, input empty, overrun, data_out);
  modport slave  (input data_in, writing, output empty, overrun, data_out);
endinterface

// File: rtl/xmtr.sv
// Serial frame transmitter. Each byte written into the one-deep holding
// register goes out as a 16-bit frame: header 8'hA5 MSB first, then the byte
// MSB first. A byte queued before the current frame ends follows with no gap.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : xmtr_if.slave (data_in, writing, empty, overrun, data_out)
module xmtr (
  input  logic   clock,
  input  logic   reset,
  xmtr_if.slave  bus
);
  localparam logic [7:0] MATCH = 8'hA5;

  typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

  state_t     state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic       full_q, full_d;
  logic       ovr_q, ovr_d;
  logic [7:0] tx_q, tx_d;
  logic [2:0] idx_q, idx_d;
  logic       dout_q, dout_d;
  logic       xfer;    // holding register moves into tx this edge
  logic       accept;

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      full_q  <= 1'b0;
      ovr_q   <= 1'b0;
      dout_q  <= 1'b0;
      hold_q  <= '0;
      tx_q    <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      full_q  <= full_d;
      ovr_q   <= ovr_d;
      dout_q  <= dout_d;
      hold_q  <= hold_d;
      tx_q    <= tx_d;
      idx_q   <= idx_d;
    end
  end

  // Next state. idx wrapping to 7 marks the end of the header / body.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (full_q) state_d = HEAD;
      HEAD:    if (idx_q == 3'd7) state_d = BODY;
      BODY:    if (idx_q == 3'd7) state_d = full_q ? HEAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Line, shifter and holding-register updates
  always_comb begin
    tx_d   = tx_q;
    idx_d  = idx_q;
    dout_d = dout_q;
    xfer   = 1'b0;
    case (state_q)
      IDLE: begin
        dout_d = 1'b0;
        xfer   = full_q;
      end
      HEAD: begin
        if (idx_q == 3'd7) begin
          // header done: first body bit, idx reloads to count the other 7
          dout_d = tx_q[7];
          tx_d   = {tx_q[6:0], 1'b0};
          idx_d  = 3'd6;
        end else begin
          dout_d = MATCH[idx_q];
          idx_d  = idx_q - 3'd1;
        end
      end
      BODY: begin
        if (idx_q == 3'd7) begin
          dout_d = 1'b0;
          xfer   = full_q;
        end else begin
          dout_d = tx_q[7];
          tx_d   = {tx_q[6:0], 1'b0};
          idx_d  = idx_q - 3'd1;
        end
      end
      default: dout_d = 1'b0;
    endcase
    if (xfer) begin
      tx_d   = hold_q;
      dout_d = MATCH[7];
      idx_d  = 3'd6;
    end

    // Acceptance looks only at the registered flag, so a write on the
    // transfer edge is still rejected.
    accept = bus.writing & ~full_q;
    hold_d = accept ? bus.data_in : hold_q;
    full_d = accept ? 1'b1 : (xfer ? 1'b0 : full_q);
    ovr_d  = accept ? 1'b0 : (bus.writing ? 1'b1 : ovr_q);
  end

  // Outputs straight from flops
  always_comb begin
    bus.empty    = ~full_q;
    bus.overrun  = ovr_q;
    bus.data_out = dout_q;
  end
endmodule

// File: tb/tb_xmtr.sv
module tb_xmtr;
  logic clock = 1'b0;
  logic reset = 1'b1;
  xmtr_if bus();

  xmtr dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] b;
    int         s;   // edge after which the first header bit appears
  } exp_t;

  exp_t q[$];
  int   vecs = 0;
  int   errs = 0;
  int   cyc  = 0;
  // model: hold occupied after edge pa up to (not after) edge pr
  int   pa = -100, pr = -100, last_s = -100;

  task automatic tick();
    @(posedge clock);
    cyc++;
    #1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    vecs++;
    if (act != req) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, req, cyc);
    end
  endtask

  task automatic do_write(input logic [7:0] b);
    int k;
    exp_t e;
    bus.writing = 1'b1;
    bus.data_in = b;
    tick();
    bus.writing = 1'b0;
    k = cyc;
    if (k > pa && k <= pr) begin
      chk("overrun_set", bus.overrun, 1);
    end else begin
      pa = k;
      pr = (k + 1 > last_s + 16) ? k + 1 : last_s + 16;
      last_s = pr;
      e.b = b;
      e.s = pr;
      q.push_back(e);
      chk("overrun_clr", bus.overrun, 0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q.delete();
    pa = -100; pr = -100; last_s = -100;
    chk("rst_dout", bus.data_out, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_ovr", bus.overrun, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Monitor: a frame starts on the first 1 seen while not collecting;
  // the header MSB is 1, so back-to-back frames are found the same way.
  logic        col = 1'b0;
  logic [15:0] sh;
  int          nb, st;
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      col = 1'b0;
    end else begin
      chk("empty", bus.empty, (cyc >= pa && cyc < pr) ? 0 : 1);
      if (!col) begin
        if (bus.data_out) begin
          col = 1'b1; sh = 16'h1; nb = 1; st = cyc;
        end
      end else begin
        sh = {sh[14:0], bus.data_out};
        nb++;
      end
      if (col && nb == 16) begin
        col = 1'b0;
        if (q.size() == 0) begin
          chk("spurious_frame", sh, 0);
        end else begin
          e = q.pop_front();
          chk("frame", sh, {8'hA5, e.b});
          chk("frame_start", st, e.s);
        end
      end
    end
  end

  initial begin
    bus.writing = 1'b0;
    bus.data_in = '0;
    idle(2);
    do_reset();
    idle(20);

    // single frame
    do_write(8'h3C);
    idle(20);

    // back-to-back: second write lands while the first is in BODY
    do_write(8'h81);
    idle(10);
    do_write(8'h7E);
    idle(40);

    // overrun: write on the transfer edge is rejected
    do_write(8'h55);
    do_write(8'hFF);
    idle(5);
    chk("overrun_sticky", bus.overrun, 1);
    idle(20);
    do_write(8'h12);
    idle(20);

    // reset at header bit 4
    do_write(8'hC3);
    idle(4);
    do_reset();
    idle(3);
    do_write(8'h96);
    idle(20);

    // randomised writes, spacing sometimes short enough to overrun
    for (int i = 0; i < 40; i++) begin
      do_write(8'($urandom));
      idle($urandom_range(0, 22));
    end

    for (int i = 0; i < 60 && q.size() != 0; i++) tick();
    idle(2);
    chk("drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
